// File: rtl/ssp_rx_fifo_cntl.sv
// ----------------------------------------------------------------------------
// ssp_rx_fifo_cntl
// Control logic for the 8-entry SSP receive FIFO. The SSP core signals each
// received frame by toggling RxFWrPtrIncSync (already in the PCLK domain), and
// the APB drains the FIFO with SSPDR reads. This block keeps the write/read
// pointers, the wrap bit and the fill level, and produces the RNE/RFF status
// and the receive-service, overrun and receive-timeout interrupts.
//
// Optional feature macro: SSP_RX_TIMEOUT_EN
//   defined   : timeout counter, RTRIS and RTMIS are implemented
//   undefined : no counter flops, RTRIS/RTMIS tied low, RTIC ignored
// ----------------------------------------------------------------------------
module ssp_rx_fifo_cntl #(
    parameter int TIMEOUT_CYCLES = 64  // idle cycles with data before RTRIS, 2..255
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       RxFWrPtrIncSync,
    input  logic       SSPDRRd,
    input  logic       RORIC,
    input  logic       RTIC,
    input  logic       RXIM,
    input  logic       RORIM,
    input  logic       RTIM,
    output logic       RNE,
    output logic       RFF,
    output logic       RXRIS,
    output logic       RXMIS,
    output logic       RORRIS,
    output logic       RORMIS,
    output logic       RTRIS,
    output logic       RTMIS,
    output logic       RegFileWrEn,
    output logic [2:0] WrPtr,
    output logic [2:0] RdPtr
);

    logic       delWrInc;    // previous value of the write-increment level
    logic       wrReq;       // one-cycle pulse per toggle of the level
    logic       rdValid;     // read of a non-empty FIFO
    logic       wrValid;     // write that the FIFO accepts
    logic       overrun;     // frame dropped because the FIFO is full
    logic       wrap;        // distinguishes full from empty when pointers match
    logic       wrapToggle;
    logic [3:0] fillLevel;   // 0..8 entries held
    logic       rneNext;
    logic       rffNext;

    // Each toggle of the synchronised level is exactly one frame.
    assign wrReq   = RxFWrPtrIncSync ^ delWrInc;

    // Reads of an empty FIFO have no effect at all.
    assign rdValid = SSPDRRd & RNE;

    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wrValid = wrReq & (~RFF | rdValid);
    assign overrun = wrReq & RFF & ~rdValid;

    assign RegFileWrEn = wrValid;

    // Both pointers wrapping together leaves the distance between them unchanged.
    assign wrapToggle = ((WrPtr == 3'd7) & wrValid) ^ ((RdPtr == 3'd7) & rdValid);

    assign fillLevel = {wrap, WrPtr} - {1'b0, RdPtr};

    // Next-state of the empty/full flags from the current level and strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
        rneNext = RNE;
        rffNext = RFF;
        if ((fillLevel == 4'd0) && wrValid) begin
            rneNext = 1'b1;
        end else if ((fillLevel == 4'd1) && rdValid && !wrValid) begin
            rneNext = 1'b0;
        end
        if ((fillLevel == 4'd7) && wrValid && !rdValid) begin
            rffNext = 1'b1;
        end else if ((fillLevel == 4'd8) && rdValid && !wrValid) begin
            rffNext = 1'b0;
        end
    end

    // Toggle edge detector for the write-increment level.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            delWrInc <= 1'b0;
        end else begin
            delWrInc <= RxFWrPtrIncSync;
        end
    end

    // Pointers and wrap bit. The entry storage lives in the RX register file
    // and is deliberately not reset here: clearing the pointers already makes
    // every stale entry unreachable.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            WrPtr <= 3'd0;
            RdPtr <= 3'd0;
            wrap  <= 1'b0;
        end else begin
            if (wrValid) begin
                WrPtr <= WrPtr + 3'd1;
            end
            if (rdValid) begin
                RdPtr <= RdPtr + 3'd1;
            end
            if (wrapToggle) begin
                wrap <= ~wrap;
            end
        end
    end

    // Registered status flags and the receive-service interrupt.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            RNE   <= 1'b0;
            RFF   <= 1'b0;
            RXRIS <= 1'b0;
        end else begin
            RNE   <= rneNext;
            RFF   <= rffNext;
            RXRIS <= (fillLevel >= 4'd4);
        end
    end

    // Sticky overrun interrupt; a new overrun beats a coincident clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            RORRIS <= 1'b0;
        end else begin
            RORRIS <= overrun | (RORRIS & ~RORIC);
        end
    end

`ifdef SSP_RX_TIMEOUT_EN
    localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeoutCnt;
    logic       timeoutHit;

    // Counter sits at its ceiling and the FIFO is still idle with data.
    assign timeoutHit = (timeoutCnt == TimeoutMax) & RNE & ~wrValid & ~rdValid;

    // Idle-cycle counter, restarted by any FIFO activity or by emptiness.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            timeoutCnt <= 8'd0;
        end else if (wrValid || rdValid || !RNE) begin
            timeoutCnt <= 8'd0;
        end else if (timeoutCnt != TimeoutMax) begin
            timeoutCnt <= timeoutCnt + 8'd1;
        end
    end

    // Sticky timeout interrupt; cleared by RTIC or a data read, set wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            RTRIS <= 1'b0;
        end else begin
            RTRIS <= timeoutHit | (RTRIS & ~RTIC & ~rdValid);
        end
    end
`else
    logic unusedTimeoutInputs;

    // Timeout hardware is absent: the raw flag is constant and RTIC is ignored.
    assign RTRIS               = 1'b0;
    assign unusedTimeoutInputs = RTIC & (TIMEOUT_CYCLES != 0);
`endif

    assign RXMIS  = RXRIS  & RXIM;
    assign RORMIS = RORRIS & RORIM;
    assign RTMIS  = RTRIS  & RTIM;

endmodule

// File: tb/tb_ssp_rx_fifo_cntl.sv
// ----------------------------------------------------------------------------
// tb_ssp_rx_fifo_cntl
// Self-checking bench for ssp_rx_fifo_cntl. The reference model tracks the
// FIFO as an occupancy count plus frame/read indices and derives every status
// and interrupt from that count. Directed phases follow the block's intended
// use, then a long randomized phase with idle stretches and mid-run resets.
// Honours SSP_RX_TIMEOUT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ssp_rx_fifo_cntl;

    localparam int TimeoutCycles = 64;
`ifdef SSP_RX_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic       PCLK;
    logic       PRESETn;
    logic       RxFWrPtrIncSync;
    logic       SSPDRRd;
    logic       RORIC;
    logic       RTIC;
    logic       RXIM;
    logic       RORIM;
    logic       RTIM;
    logic       RNE;
    logic       RFF;
    logic       RXRIS;
    logic       RXMIS;
    logic       RORRIS;
    logic       RORMIS;
    logic       RTRIS;
    logic       RTMIS;
    logic       RegFileWrEn;
    logic [2:0] WrPtr;
    logic [2:0] RdPtr;

    ssp_rx_fifo_cntl #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .RxFWrPtrIncSync(RxFWrPtrIncSync),
        .SSPDRRd        (SSPDRRd),
        .RORIC          (RORIC),
        .RTIC           (RTIC),
        .RXIM           (RXIM),
        .RORIM          (RORIM),
        .RTIM           (RTIM),
        .RNE            (RNE),
        .RFF            (RFF),
        .RXRIS          (RXRIS),
        .RXMIS          (RXMIS),
        .RORRIS         (RORRIS),
        .RORMIS         (RORMIS),
        .RTRIS          (RTRIS),
        .RTMIS          (RTMIS),
        .RegFileWrEn    (RegFileWrEn),
        .WrPtr          (WrPtr),
        .RdPtr          (RdPtr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: how many frames are held, how many were ever written
    // and read (pointers are these counts mod 8), and the interrupt flags.
    int mLevel;
    int mWrCount;
    int mRdCount;
    int mIdle;
    bit mRxris;
    bit mRor;
    bit mRt;
    bit mIncLevel;

    task automatic check(input string tag, input int observed, input int expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic model_reset();
        mLevel    = 0;
        mWrCount  = 0;
        mRdCount  = 0;
        mIdle     = 0;
        mRxris    = 1'b0;
        mRor      = 1'b0;
        mRt       = 1'b0;
        mIncLevel = 1'b0;
    endtask

    // Compare every registered output against the model's view of the FIFO.
    task automatic check_state();
        check("WrPtr",  int'(WrPtr),  mWrCount % 8);
        check("RdPtr",  int'(RdPtr),  mRdCount % 8);
        check("RNE",    int'(RNE),    int'(mLevel > 0));
        check("RFF",    int'(RFF),    int'(mLevel == 8));
        check("RXRIS",  int'(RXRIS),  int'(mRxris));
        check("RXMIS",  int'(RXMIS),  int'(mRxris & RXIM));
        check("RORRIS", int'(RORRIS), int'(mRor));
        check("RORMIS", int'(RORMIS), int'(mRor & RORIM));
        check("RTRIS",  int'(RTRIS),  int'(mRt));
        check("RTMIS",  int'(RTMIS),  int'(mRt & RTIM));
    endtask

    // One PCLK cycle: check state, apply inputs, check the write strobe,
    // then advance the model to what the next edge should produce.
    task automatic cycle(input bit toggle, input bit rd, input bit roric, input bit rtic);
        bit wrReq;
        bit rdOk;
        bit wrOk;
        bit drop;
        bit tHit;
        @(negedge PCLK);
        check_state();
        RxFWrPtrIncSync = toggle ? ~RxFWrPtrIncSync : RxFWrPtrIncSync;
        SSPDRRd         = rd;
        RORIC           = roric;
        RTIC            = rtic;
        #1;
        wrReq = (RxFWrPtrIncSync != mIncLevel);
        rdOk  = rd && (mLevel > 0);
        wrOk  = wrReq && ((mLevel < 8) || rdOk);
        drop  = wrReq && (mLevel == 8) && !rdOk;
        check("RegFileWrEn", int'(RegFileWrEn), int'(wrOk));

        tHit      = TimeoutOn && (mIdle == TimeoutCycles - 1) && (mLevel > 0) && !wrOk && !rdOk;
        mRt       = tHit || (mRt && !rtic && !rdOk);
        if (wrOk || rdOk || mLevel == 0) mIdle = 0;
        else if (mIdle < TimeoutCycles - 1) mIdle = mIdle + 1;
        mRxris    = (mLevel >= 4);
        mRor      = drop || (mRor && !roric);
        mLevel    = mLevel + int'(wrOk) - int'(rdOk);
        mWrCount  = mWrCount + int'(wrOk);
        mRdCount  = mRdCount + int'(rdOk);
        mIncLevel = RxFWrPtrIncSync;
    endtask

    // Asynchronous reset asserted between edges; the core side returns its
    // toggle level to 0 at the same time.
    task automatic do_reset();
        @(negedge PCLK);
        #2;
        PRESETn         = 1'b0;
        RxFWrPtrIncSync = 1'b0;
        SSPDRRd         = 1'b0;
        RORIC           = 1'b0;
        RTIC            = 1'b0;
        #1;
        model_reset();
        check_state();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        PRESETn         = 1'b0;
        RxFWrPtrIncSync = 1'b0;
        SSPDRRd         = 1'b0;
        RORIC           = 1'b0;
        RTIC            = 1'b0;
        RXIM            = 1'b1;
        RORIM           = 1'b1;
        RTIM            = 1'b1;
        model_reset();

        // Reset state.
        do_reset();
        cycle(0, 0, 0, 0);

        // Fill with eight toggles, two cycles apart.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            cycle(0, 0, 0, 0);
        end

        // Overrun, clear, then overrun coincident with clear.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);

        // Full FIFO, read coincident with a new frame.
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Drain with nine reads; the last one hits an empty FIFO.
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // One frame then a long idle stretch, then a read.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < TimeoutCycles + 6; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Timeout cleared by RTIC rather than by a read.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < TimeoutCycles + 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // Randomized traffic with idle stretches, mask changes and resets.
        for (int i = 0; i < 4000; i++) begin
            int mode;
            mode = $urandom_range(0, 99);
            if (mode == 0) begin
                do_reset();
            end else if (mode < 3) begin
                int idleLen;
                idleLen = $urandom_range(TimeoutCycles - 4, TimeoutCycles + 8);
                for (int j = 0; j < idleLen; j++) cycle(0, 0, 0, 0);
            end else begin
                RXIM  = 1'($urandom_range(0, 1));
                RORIM = 1'($urandom_range(0, 1));
                RTIM  = 1'($urandom_range(0, 1));
                cycle(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 35),
                      ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10));
            end
        end

        @(negedge PCLK);
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
